// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: command FIFO feeding the request-to-send
// sequence on the open-drain clock/data pads, with ack and timeout reporting.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          cmd_valid,
  input  logic [7:0]                    cmd_data,
  output logic                          cmd_ready,
  input  logic                          ps2_clk_i,
  input  logic                          ps2_data_i,
  output logic                          ps2_clk_oe,
  output logic                          ps2_data_oe,
  output logic                          rx_inhibit,
  output logic                          tx_busy,
  output logic                          tx_ack,
  output logic                          tx_error_no_ack,
  output logic                          tx_error_timeout,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_RELEASE
  } state_t;

  state_t        state, state_n;
  logic          clk_s1, clk_s2, clk_d, data_s1, data_s2;
  logic          fe;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;
  logic [IW-1:0] inh_cnt, inh_n;
  logic [TW-1:0] to_cnt, to_n;
  logic [9:0]    frame, frame_n;
  logic [3:0]    bitcnt, bitcnt_n;
  logic          clk_oe_n, data_oe_n, ack_n, nack_n, tmo_n;

  // Pad synchronizers plus edge-detect stage; reset to the idle-high bus level
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      clk_d   <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk_i;
      clk_s2  <= clk_s1;
      clk_d   <= clk_s2;
      data_s1 <= ps2_data_i;
      data_s2 <= data_s1;
    end
  end

  assign fe = clk_d & ~clk_s2;

  assign cmd_ready  = (count != (AW+1)'(FIFO_DEPTH));
  assign push       = cmd_valid & cmd_ready;
  assign pop        = (state == S_IDLE) && (count != '0);
  assign fifo_count = count;
  assign rx_inhibit = (state != S_IDLE);
  assign tx_busy    = (state != S_IDLE) || (count != '0);

  // FIFO storage, written only on accepted pushes
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= cmd_data;
  end

  // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FSM state, registered pad enables, counters and status pulses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state            <= S_IDLE;
      ps2_clk_oe       <= 1'b0;
      ps2_data_oe      <= 1'b0;
      tx_ack           <= 1'b0;
      tx_error_no_ack  <= 1'b0;
      tx_error_timeout <= 1'b0;
      inh_cnt          <= '0;
      to_cnt           <= '0;
      frame            <= '0;
      bitcnt           <= '0;
    end else begin
      state            <= state_n;
      ps2_clk_oe       <= clk_oe_n;
      ps2_data_oe      <= data_oe_n;
      tx_ack           <= ack_n;
      tx_error_no_ack  <= nack_n;
      tx_error_timeout <= tmo_n;
      inh_cnt          <= inh_n;
      to_cnt           <= to_n;
      frame            <= frame_n;
      bitcnt           <= bitcnt_n;
    end
  end

  // Next state and next pad/pulse values; pad enables are registered, so each
  // branch sets the value that appears from the following edge onward
  always_comb begin
    state_n   = state;
    clk_oe_n  = ps2_clk_oe;
    data_oe_n = ps2_data_oe;
    inh_n     = inh_cnt;
    to_n      = to_cnt;
    frame_n   = frame;
    bitcnt_n  = bitcnt;
    ack_n     = 1'b0;
    nack_n    = 1'b0;
    tmo_n     = 1'b0;
    unique case (state)
      S_IDLE: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        if (pop) begin
          frame_n  = {1'b1, ~^mem[rd_ptr], mem[rd_ptr]};
          bitcnt_n = '0;
          inh_n    = '0;
          state_n  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        clk_oe_n  = 1'b1;
        data_oe_n = 1'b0;
        if (inh_cnt == INH_LAST) begin
          data_oe_n = 1'b1;
          state_n   = S_REQ;
        end else begin
          inh_n = inh_cnt + 1'b1;
        end
      end
      S_REQ: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b1;
        to_n      = TMO_LOAD;
        state_n   = S_SHIFT;
      end
      S_SHIFT: begin
        clk_oe_n = 1'b0;
        to_n     = fe ? TMO_LOAD : to_cnt - 1'b1;
        if (fe) begin
          data_oe_n = ~frame[0];
          frame_n   = {1'b1, frame[9:1]};
          bitcnt_n  = bitcnt + 1'b1;
          if (bitcnt == 4'd9) state_n = S_ACK;
        end
      end
      S_ACK: begin
        clk_oe_n = 1'b0;
        to_n     = fe ? TMO_LOAD : to_cnt - 1'b1;
        if (fe) begin
          ack_n   = ~data_s2;
          nack_n  = data_s2;
          state_n = S_RELEASE;
        end
      end
      S_RELEASE: begin
        clk_oe_n = 1'b0;
        to_n     = fe ? TMO_LOAD : to_cnt - 1'b1;
        if (clk_s2 && data_s2) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    // Timeout overrides any other outcome in the waiting states; firing when
    // the counter would step from 1 to 0 gives exactly TIMEOUT_CYCLES cycles
    if ((state == S_SHIFT || state == S_ACK || state == S_RELEASE) &&
        !fe && to_cnt == TW'(1)) begin
      clk_oe_n  = 1'b0;
      data_oe_n = 1'b0;
      ack_n     = 1'b0;
      nack_n    = 1'b0;
      tmo_n     = 1'b1;
      state_n   = S_IDLE;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model on the pads.
module tb_ps2_host_tx;

  localparam int INH = 50;
  localparam int TMO = 400;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       ps2_clk_i, ps2_data_i;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       rx_inhibit, tx_busy, tx_ack, tx_error_no_ack, tx_error_timeout;
  logic [2:0] fifo_count;
  logic       dev_clk_lo = 1'b0;
  logic       dev_data_lo = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_cnt  = 0;
  int nack_cnt = 0;
  int tmo_cnt  = 0;

  always #5 clk = ~clk;

  // Open-drain wired-AND of host and device on both pads
  assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_lo);
  assign ps2_data_i = ~(ps2_data_oe | dev_data_lo);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .rx_inhibit(rx_inhibit), .tx_busy(tx_busy), .tx_ack(tx_ack),
    .tx_error_no_ack(tx_error_no_ack), .tx_error_timeout(tx_error_timeout),
    .fifo_count(fifo_count)
  );

  // Pulse counters sampled away from the active edge
  always @(negedge clk) begin
    if (tx_ack)           ack_cnt  <= ack_cnt + 1;
    if (tx_error_no_ack)  nack_cnt <= nack_cnt + 1;
    if (tx_error_timeout) tmo_cnt  <= tmo_cnt + 1;
  end

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    cmd_valid = 1'b1;
    cmd_data  = b;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_clk_oe(input logic lvl, input string tag);
    int n = 0;
    while (ps2_clk_oe !== lvl && n < 2000) begin
      @(negedge clk);
      n++;
    end
    expect_eq(tag, ps2_clk_oe, lvl);
  endtask

  // Wait for inhibit then clock release, start bit must be on the pad
  task automatic wait_start(input string tag);
    wait_clk_oe(1'b1, {tag, "_inhibit"});
    wait_clk_oe(1'b0, {tag, "_shift"});
    expect_eq({tag, "_start"}, ps2_data_oe, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (tx_busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    expect_eq(tag, tx_busy, 1'b0);
  endtask

  // Device model: nclk clock pulses of 20 cycles; samples host data just
  // before each rising edge, optionally acks on the 11th pulse
  task automatic dev_xfer(input int nclk, input bit do_ack,
                          output logic [9:0] frame, output int ack_lat);
    frame   = '0;
    ack_lat = -1;
    for (int k = 0; k < nclk; k++) begin
      if (k == 10 && do_ack) dev_data_lo = 1'b1;
      repeat (5) @(negedge clk);
      dev_clk_lo = 1'b1;
      if (k == 10) begin
        for (int j = 1; j <= 10; j++) begin
          @(negedge clk);
          if (ack_lat < 0 && (tx_ack || tx_error_no_ack)) ack_lat = j;
        end
      end else begin
        repeat (10) @(negedge clk);
        frame[k] = ~ps2_data_oe;
      end
      dev_clk_lo = 1'b0;
      if (k == 10) dev_data_lo = 1'b0;
      repeat (5) @(negedge clk);
    end
  endtask

  logic [7:0] fill_tbl [4] = '{8'h00, 8'h01, 8'hFF, 8'hF4};
  logic [9:0] frame_tbl [3] = '{10'h300, 10'h201, 10'h3FF};

  initial begin
    logic [9:0] fr;
    int lat, k, a0, n0, t0;
    logic last_doe;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_data = '0;
    repeat (3) @(negedge clk);
    expect_eq("rst_ready", cmd_ready, 1'b1);
    expect_eq("rst_clk_oe", ps2_clk_oe, 1'b0);
    expect_eq("rst_data_oe", ps2_data_oe, 1'b0);
    expect_eq("rst_count", fifo_count, 3'd0);
    expect_eq("rst_busy_inh", {tx_busy, rx_inhibit}, 2'b00);
    expect_eq("rst_pulses", {tx_ack, tx_error_no_ack, tx_error_timeout}, 3'b000);
    rst_n = 1'b1;
    @(negedge clk);

    // 0xED with ack, exact inhibit timing
    a0 = ack_cnt; n0 = nack_cnt; t0 = tmo_cnt;
    push_byte(8'hED);
    expect_eq("ed_count_push", fifo_count, 3'd1);
    expect_eq("ed_busy", tx_busy, 1'b1);
    expect_eq("ed_clk_oe_n", ps2_clk_oe, 1'b0);
    @(negedge clk);
    expect_eq("ed_count_pop", fifo_count, 3'd0);
    expect_eq("ed_rx_inhibit", rx_inhibit, 1'b1);
    expect_eq("ed_clk_oe_n1", ps2_clk_oe, 1'b0);
    @(negedge clk);
    expect_eq("ed_clk_oe_n2", ps2_clk_oe, 1'b1);
    expect_eq("ed_data_oe_n2", ps2_data_oe, 1'b0);
    k = 0;
    while (!ps2_data_oe && k < 1000) begin
      @(negedge clk);
      k++;
    end
    expect_eq("ed_inhibit_len", k, INH);
    expect_eq("ed_req_clk", ps2_clk_oe, 1'b1);
    @(negedge clk);
    expect_eq("ed_shift_clk", ps2_clk_oe, 1'b0);
    expect_eq("ed_start", ps2_data_oe, 1'b1);
    dev_xfer(11, 1'b1, fr, lat);
    expect_eq("ed_frame", fr, 10'h3ED);
    expect_eq("ed_ack_lat", lat, 3);
    wait_idle("ed_idle");
    expect_eq("ed_acks", ack_cnt - a0, 1);
    expect_eq("ed_nacks", nack_cnt - n0, 0);
    expect_eq("ed_tmos", tmo_cnt - t0, 0);

    // 0x01, device leaves data high at the ack edge
    a0 = ack_cnt; n0 = nack_cnt;
    push_byte(8'h01);
    wait_start("n01");
    dev_xfer(11, 1'b0, fr, lat);
    expect_eq("n01_frame", fr, 10'h201);
    expect_eq("n01_nack_lat", lat, 3);
    wait_idle("n01_idle");
    expect_eq("n01_nacks", nack_cnt - n0, 1);
    expect_eq("n01_acks", ack_cnt - a0, 0);

    // 0xFF, device silent; fill the FIFO meanwhile
    a0 = ack_cnt; t0 = tmo_cnt;
    push_byte(8'hFF);
    wait_clk_oe(1'b1, "ff_inhibit");
    wait_clk_oe(1'b0, "ff_shift");
    k = 0;
    last_doe = ps2_data_oe;
    while (!tx_error_timeout && k < 1000) begin
      if (k >= 10 && k <= 13) begin
        cmd_valid = 1'b1;
        cmd_data  = fill_tbl[k-10];
      end else if (k == 14) begin
        expect_eq("fill_count", fifo_count, 3'd4);
        expect_eq("fill_ready", cmd_ready, 1'b0);
        cmd_valid = 1'b1;
        cmd_data  = 8'h55;
      end else if (k == 15) begin
        expect_eq("fill_refused", fifo_count, 3'd4);
        cmd_valid = 1'b0;
      end
      last_doe = ps2_data_oe;
      @(negedge clk);
      k++;
    end
    cmd_valid = 1'b0;
    expect_eq("ff_tmo_time", k, TMO);
    expect_eq("ff_pre_data_oe", last_doe, 1'b1);
    expect_eq("ff_tmo_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    expect_eq("ff_tmo_cnt", tmo_cnt - t0 + (tx_error_timeout ? 1 : 0), 1);
    expect_eq("ff_no_ack", ack_cnt - a0, 0);

    // Queued bytes leave in order with acks
    for (int b = 0; b < 3; b++) begin
      a0 = ack_cnt;
      wait_start($sformatf("q%0d", b));
      dev_xfer(11, 1'b1, fr, lat);
      expect_eq($sformatf("q%0d_frame", b), fr, frame_tbl[b]);
      expect_eq($sformatf("q%0d_ack", b), ack_cnt - a0, 1);
    end

    // 0xF4 interrupted by reset after its 4th falling edge
    wait_start("f4");
    push_byte(8'hAA);
    expect_eq("f4_count", fifo_count, 3'd1);
    dev_xfer(4, 1'b0, fr, lat);
    expect_eq("f4_bits", fr[3:0], 4'h4);
    expect_eq("f4_pre_rst_doe", ps2_data_oe, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    expect_eq("arst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    expect_eq("arst_count", fifo_count, 3'd0);
    expect_eq("arst_ready", cmd_ready, 1'b1);
    expect_eq("arst_busy_inh", {tx_busy, rx_inhibit}, 2'b00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    a0 = ack_cnt;
    push_byte(8'h0F);
    wait_start("p0f");
    dev_xfer(11, 1'b1, fr, lat);
    expect_eq("p0f_frame", fr, 10'h30F);
    wait_idle("p0f_idle");
    expect_eq("p0f_ack", ack_cnt - a0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
